// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared timing defaults, pattern modes and bar colours for the VGA generator
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int BOX_SIZE     = 32;

  typedef enum logic [2:0] {
    PAT_BARS  = 3'd0,
    PAT_CHECK = 3'd1,
    PAT_RAMP  = 3'd2,
    PAT_SOLID = 3'd3,
    PAT_BOX   = 3'd4
  } pattern_e;

  // {R,G,B} on/off flags per bar, widened to full scale in the datapath
  localparam logic [2:0] BAR_COLORS [8] = '{
    3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
  };

  // One bounce step on a 0..lim axis: {moving_negative, new_position}
  function automatic logic [12:0] bounce_step(input logic [11:0] pos, input logic neg,
                                              input logic [11:0] lim);
    logic n;
    if (lim == 12'd0) return {neg, pos};
    n = neg;
    if (!neg && pos == lim) n = 1'b1;
    else if (neg && pos == 12'd0) n = 1'b0;
    return {n, n ? pos - 12'd1 : pos + 12'd1};
  endfunction

endpackage

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - pixel clock divider, raster counters, sync/active decode and frame start
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = H_ACTIVE_DEF,
  parameter int H_FP      = H_FP_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BP      = H_BP_DEF,
  parameter int V_ACTIVE  = V_ACTIVE_DEF,
  parameter int V_FP      = V_FP_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BP      = V_BP_DEF,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int CLK_DIV   = 2
) (
  input  logic        clk_50mhz,
  input  logic        reset_n,
  output logic        pix_ce,
  output logic        vga_clk,
  output logic [11:0] hc,
  output logic [11:0] vc,
  output logic        hsync,
  output logic        vsync,
  output logic        active,
  output logic        frame_start
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [11:0] H_LAST = 12'(HT - 1);
  localparam logic [11:0] V_LAST = 12'(VT - 1);
  localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
  localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0]  DIV_HALF = 8'(CLK_DIV / 2);
  localparam logic        HS_ON = 1'(HSYNC_POL);
  localparam logic        VS_ON = 1'(VSYNC_POL);

  logic [7:0] div_cnt;

  always_ff @(posedge clk_50mhz or negedge reset_n) begin
    if (!reset_n) div_cnt <= '0;
    else if (pix_ce) div_cnt <= '0;
    else div_cnt <= div_cnt + 8'd1;
  end

  always_ff @(posedge clk_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      hc <= '0;
      vc <= '0;
    end else if (pix_ce) begin
      if (hc == H_LAST) begin
        hc <= '0;
        vc <= (vc == V_LAST) ? 12'd0 : vc + 12'd1;
      end else begin
        hc <= hc + 12'd1;
      end
    end
  end

  assign pix_ce      = (div_cnt == DIV_LAST);
  assign vga_clk     = (div_cnt >= DIV_HALF);
  assign hsync       = (hc >= HS_BEG && hc < HS_END) ? HS_ON : ~HS_ON;
  assign vsync       = (vc >= VS_BEG && vc < VS_END) ? VS_ON : ~VS_ON;
  assign active      = (hc < H_ACT) && (vc < V_ACT);
  assign frame_start = pix_ce && (hc == 12'd0) && (vc == 12'd0);

endmodule

// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - test pattern generator: per-frame mode latch, bouncing box, registered VGA outputs
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = H_ACTIVE_DEF,
  parameter int H_FP      = H_FP_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BP      = H_BP_DEF,
  parameter int V_ACTIVE  = V_ACTIVE_DEF,
  parameter int V_FP      = V_FP_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BP      = V_BP_DEF,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int CLK_DIV   = 2,
  parameter int COLOR_W   = 8
) (
  input  logic                   clk_50mhz,
  input  logic                   reset_n,
  input  logic [2:0]             mode_sel,
  input  logic [3*COLOR_W-1:0]   solid_rgb,
  output logic                   vga_clk,
  output logic                   vga_blank_n,
  output logic                   vga_sync_n,
  output logic                   vga_hsync,
  output logic                   vga_vsync,
  output logic [COLOR_W-1:0]     vga_r,
  output logic [COLOR_W-1:0]     vga_g,
  output logic [COLOR_W-1:0]     vga_b,
  output logic                   frame_start,
  output logic [15:0]            frame_cnt,
  output logic [7:0]             leds
);

  localparam int BAR_W = H_ACTIVE / 8;
  localparam logic [11:0] X_LIM  = 12'(H_ACTIVE - BOX_SIZE);
  localparam logic [11:0] Y_LIM  = 12'(V_ACTIVE - BOX_SIZE);
  localparam logic [11:0] BOX_SZ = 12'(BOX_SIZE);
  localparam logic [31:0] RAMP_MAX = 32'((1 << COLOR_W) - 1);
  localparam logic [31:0] RAMP_DEN = 32'(H_ACTIVE - 1);
  localparam logic HS_ON = 1'(HSYNC_POL);
  localparam logic VS_ON = 1'(VSYNC_POL);

  logic                 pix_ce, t_hsync, t_vsync, t_active;
  logic [11:0]          hc, vc;
  logic [2:0]           cur_mode, nx_mode, bar_idx, bar_rgb;
  logic [11:0]          box_x, box_y, nx_x, nx_y;
  logic                 box_dx, box_dy, nx_dx, nx_dy;
  logic                 in_box;
  logic [COLOR_W-1:0]   ramp_chan;
  logic [3*COLOR_W-1:0] pix_rgb, rgb_q;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HSYNC_POL(HSYNC_POL), .VSYNC_POL(VSYNC_POL), .CLK_DIV(CLK_DIV)
  ) u_timing (
    .clk_50mhz  (clk_50mhz),
    .reset_n    (reset_n),
    .pix_ce     (pix_ce),
    .vga_clk    (vga_clk),
    .hc         (hc),
    .vc         (vc),
    .hsync      (t_hsync),
    .vsync      (t_vsync),
    .active     (t_active),
    .frame_start(frame_start)
  );

  // The nx_* values are what the frame-start edge will latch; using them for the
  // pixel at (0,0) keeps every pixel of a frame on the same mode and box position.
  always_comb begin
    nx_mode = cur_mode;
    nx_x    = box_x;
    nx_y    = box_y;
    nx_dx   = box_dx;
    nx_dy   = box_dy;
    if (frame_start) begin
      nx_mode = mode_sel;
      if (mode_sel == PAT_BOX) begin
        if (cur_mode != PAT_BOX) begin
          nx_x  = '0;
          nx_y  = '0;
          nx_dx = 1'b0;
          nx_dy = 1'b0;
        end else begin
          {nx_dx, nx_x} = bounce_step(box_x, box_dx, X_LIM);
          {nx_dy, nx_y} = bounce_step(box_y, box_dy, Y_LIM);
        end
      end
    end
  end

  always_comb begin
    bar_idx = 3'd7;
    for (int i = 6; i >= 0; i--) begin
      if (hc < 12'(BAR_W * (i + 1))) bar_idx = 3'(i);
    end
    bar_rgb   = BAR_COLORS[bar_idx];
    ramp_chan = COLOR_W'((32'(hc) * RAMP_MAX) / RAMP_DEN);
    in_box    = (hc >= nx_x) && (hc < nx_x + BOX_SZ) && (vc >= nx_y) && (vc < nx_y + BOX_SZ);
    pix_rgb   = '0;
    case (nx_mode)
      PAT_BARS:  pix_rgb = {{COLOR_W{bar_rgb[2]}}, {COLOR_W{bar_rgb[1]}}, {COLOR_W{bar_rgb[0]}}};
      PAT_CHECK: pix_rgb = (hc[5] ^ vc[5]) ? '0 : '1;
      PAT_RAMP:  pix_rgb = {3{ramp_chan}};
      PAT_SOLID: pix_rgb = solid_rgb;
      PAT_BOX:   pix_rgb = in_box ? '1 : {{(2*COLOR_W){1'b0}}, {COLOR_W{1'b1}}};
      default:   pix_rgb = '0;
    endcase
  end

  always_ff @(posedge clk_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      rgb_q       <= '0;
      vga_blank_n <= 1'b0;
      vga_hsync   <= ~HS_ON;
      vga_vsync   <= ~VS_ON;
      frame_cnt   <= '0;
      cur_mode    <= PAT_BARS;
      box_x       <= '0;
      box_y       <= '0;
      box_dx      <= 1'b0;
      box_dy      <= 1'b0;
    end else if (pix_ce) begin
      rgb_q       <= t_active ? pix_rgb : '0;
      vga_blank_n <= t_active;
      vga_hsync   <= t_hsync;
      vga_vsync   <= t_vsync;
      cur_mode    <= nx_mode;
      box_x       <= nx_x;
      box_y       <= nx_y;
      box_dx      <= nx_dx;
      box_dy      <= nx_dy;
      if (frame_start) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  assign vga_r      = rgb_q[3*COLOR_W-1:2*COLOR_W];
  assign vga_g      = rgb_q[2*COLOR_W-1:COLOR_W];
  assign vga_b      = rgb_q[COLOR_W-1:0];
  assign vga_sync_n = 1'b0;
  assign leds       = {5'b0, cur_mode};

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb/tb_vga_pattern_gen.sv - self-checking bench: raster-arithmetic model plus literal spot checks
module tb_vga_pattern_gen;

  localparam int HA = 40, HFP = 2, HS = 4, HBP = 2;
  localparam int VA = 36, VFP = 1, VS = 2, VBP = 1;
  localparam int D = 2;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FPIX = HT * VT;
  localparam int FC = FPIX * D;
  localparam int XM = HA - 32, YM = VA - 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [2:0]  mode_sel;
  logic [23:0] solid_rgb;
  logic        vga_clk, vga_blank_n, vga_sync_n, vga_hsync, vga_vsync, frame_start;
  logic [7:0]  vga_r, vga_g, vga_b, leds;
  logic [15:0] frame_cnt;

  logic [2:0]  mode2 = 3'd0;
  logic [23:0] solid2 = 24'd0;
  logic        clk2, blank2, sync2, hs2, vs2, fs2;
  logic [7:0]  r2, g2, b2, leds2;
  logic [15:0] fcnt2;

  vga_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .HSYNC_POL(0), .VSYNC_POL(0), .CLK_DIV(D), .COLOR_W(8)
  ) dut (
    .clk_50mhz(clk), .reset_n(reset_n), .mode_sel(mode_sel), .solid_rgb(solid_rgb),
    .vga_clk(vga_clk), .vga_blank_n(vga_blank_n), .vga_sync_n(vga_sync_n),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .frame_start(frame_start), .frame_cnt(frame_cnt), .leds(leds)
  );

  vga_pattern_gen #(.H_ACTIVE(320), .CLK_DIV(4), .HSYNC_POL(1)) dut2 (
    .clk_50mhz(clk), .reset_n(reset_n), .mode_sel(mode2), .solid_rgb(solid2),
    .vga_clk(clk2), .vga_blank_n(blank2), .vga_sync_n(sync2),
    .vga_hsync(hs2), .vga_vsync(vs2),
    .vga_r(r2), .vga_g(g2), .vga_b(b2),
    .frame_start(fs2), .frame_cnt(fcnt2), .leds(leds2)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int tri_pos(input int j, input int m);
    int r;
    if (m == 0) return 0;
    r = j % (2 * m);
    return (r <= m) ? r : 2 * m - r;
  endfunction

  function automatic logic [23:0] pix_color(input int h, input int v, input int m, input int j,
                                             input logic [23:0] solid);
    int b, bx, by, g;
    if (h >= HA || v >= VA) return 24'h0;
    case (m)
      0: begin
        b = h / (HA / 8);
        if (b > 7) b = 7;
        case (b)
          0: return 24'hFFFFFF;
          1: return 24'hFFFF00;
          2: return 24'h00FFFF;
          3: return 24'h00FF00;
          4: return 24'hFF00FF;
          5: return 24'hFF0000;
          6: return 24'h0000FF;
          default: return 24'h000000;
        endcase
      end
      1: return (((h / 32) + (v / 32)) % 2 == 0) ? 24'hFFFFFF : 24'h000000;
      2: begin
        g = h * 255 / (HA - 1);
        return {g[7:0], g[7:0], g[7:0]};
      end
      3: return solid;
      4: begin
        bx = tri_pos(j, XM);
        by = tri_pos(j, YM);
        return (h >= bx && h < bx + 32 && v >= by && v < by + 32) ? 24'hFFFFFF : 24'h0000FF;
      end
      default: return 24'h0;
    endcase
  endfunction

  // Model state: k = clock edges since reset release; everything else derives from it
  int k = 0, m_frames = 0, cur_mode_m = 0, box_j = 0;
  int shown_f = -1, shown_h = 0, shown_v = 0;
  logic [23:0] e_rgb = 24'h0;
  logic e_blank = 1'b0, e_hs = 1'b1, e_vs = 1'b1;
  int hs2_cnt = 0, hs2_first = -1, act2_cnt = 0, last_rise = -1, rises = 0;
  logic prev_clk2 = 1'b0;

  task automatic spot(input int f, input int v, input int h, input string name,
                      input logic [31:0] act, input logic [31:0] exp);
    if (shown_f == f && shown_v == v && shown_h == h) chk(name, act, exp);
  endtask

  always @(negedge clk) begin
    int n, h, v, p;
    bit pce, fs, eclk;
    if (!reset_n) begin
      chk("reset_pins", {vga_r, vga_g, vga_b, vga_blank_n, vga_hsync, vga_vsync, vga_sync_n, vga_clk, frame_start},
          {24'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
      chk("reset_state", {frame_cnt, leds}, 24'h0);
      k = 0; m_frames = 0; cur_mode_m = 0; box_j = 0; shown_f = -1;
      e_rgb = 24'h0; e_blank = 1'b0; e_hs = 1'b1; e_vs = 1'b1;
      hs2_cnt = 0; hs2_first = -1; act2_cnt = 0; last_rise = -1; rises = 0; prev_clk2 = 1'b0;
    end else begin
      n = k / D;
      h = n % HT;
      v = (n / HT) % VT;
      pce = (k % D) == D - 1;
      fs = pce && (n % FPIX == 0);
      eclk = (k % D) >= D / 2;
      chk("pins", {vga_r, vga_g, vga_b, vga_blank_n, vga_hsync, vga_vsync, vga_sync_n, vga_clk, frame_start},
          {e_rgb, e_blank, e_hs, e_vs, 1'b0, eclk, fs});
      chk("state", {frame_cnt, leds}, {16'(m_frames), 8'(cur_mode_m)});

      spot(1, 0, 5, "bar1_px5", {vga_r, vga_g, vga_b}, 24'hFFFF00);
      spot(1, 0, 39, "bar7_px39", {vga_r, vga_g, vga_b}, 24'h000000);
      spot(1, 0, 43, "hblank_hsync", {vga_r, vga_g, vga_b, vga_blank_n, vga_hsync}, 26'h0);
      spot(1, 37, 0, "vsync_line37", {vga_vsync, vga_blank_n}, 2'b00);
      spot(1, 35, 20, "bars_after_sel", {vga_r, vga_g, vga_b}, 24'hFF00FF);
      spot(2, 0, 0, "solid_first_px", {vga_r, vga_g, vga_b}, 24'h123456);
      spot(3, 0, 0, "check_origin", {vga_r, vga_g, vga_b}, 24'hFFFFFF);
      spot(3, 0, 32, "check_x32", {vga_r, vga_g, vga_b}, 24'h000000);
      spot(4, 0, 20, "ramp_20", {vga_r, vga_g, vga_b}, 24'h828282);
      spot(4, 0, 39, "ramp_end", {vga_r, vga_g, vga_b}, 24'hFFFFFF);
      spot(13, 0, 8, "box_x8_in", {vga_r, vga_g, vga_b}, 24'hFFFFFF);
      spot(13, 0, 7, "box_x8_out", {vga_r, vga_g, vga_b}, 24'h0000FF);
      spot(14, 0, 7, "box_back_ytop", {vga_r, vga_g, vga_b}, 24'h0000FF);
      spot(14, 1, 7, "box_back_in", {vga_r, vga_g, vga_b}, 24'hFFFFFF);
      spot(16, 10, 10, "mode6_black", {vga_r, vga_g, vga_b, vga_blank_n}, 25'h1);
      spot(17, 0, 0, "box_reentry", {vga_r, vga_g, vga_b}, 24'hFFFFFF);
      spot(17, 0, 32, "box_reentry_bg", {vga_r, vga_g, vga_b}, 24'h0000FF);

      // Second instance: 320-wide line, divide-by-4, positive hsync
      if (clk2 && !prev_clk2) begin
        if (last_rise >= 0 && rises < 4) begin
          chk("d2_clk_period", 32'(k - last_rise), 32'd4);
          rises++;
        end
        last_rise = k;
      end
      prev_clk2 = clk2;
      if (k % 4 == 0 && k >= 4 && k / 4 - 1 < 480) begin
        p = k / 4 - 1;
        if (hs2) begin
          hs2_cnt++;
          if (hs2_first < 0) hs2_first = p;
        end
        if (blank2) act2_cnt++;
        if (p == 0)   chk("d2_bar0_first", {r2, g2, b2}, 24'hFFFFFF);
        if (p == 39)  chk("d2_bar0_last", {r2, g2, b2}, 24'hFFFFFF);
        if (p == 40)  chk("d2_bar1_first", {r2, g2, b2}, 24'hFFFF00);
        if (p == 279) chk("d2_bar6_last", {r2, g2, b2}, 24'h0000FF);
        if (p == 280) chk("d2_bar7_first", {r2, g2, b2}, 24'h000000);
        if (p == 320) chk("d2_blank", {r2, g2, b2, blank2}, 25'h0);
        if (p == 479) begin
          chk("d2_hs_width", 32'(hs2_cnt), 32'd96);
          chk("d2_hs_first", 32'(hs2_first), 32'd336);
          chk("d2_active_px", 32'(act2_cnt), 32'd320);
        end
      end

      if (pce) begin
        if (fs) begin
          m_frames++;
          box_j = (mode_sel == 3'd4 && cur_mode_m == 4) ? box_j + 1 : 0;
          cur_mode_m = int'(mode_sel);
        end
        e_rgb   = pix_color(h, v, cur_mode_m, box_j, solid_rgb);
        e_blank = (h < HA) && (v < VA);
        e_hs    = !(h >= HA + HFP && h < HA + HFP + HS);
        e_vs    = !(v >= VA + VFP && v < VA + VFP + VS);
        shown_f = m_frames;
        shown_h = h;
        shown_v = v;
      end
      k++;
    end
  end

  initial begin
    reset_n = 1'b0;
    mode_sel = 3'd0;
    solid_rgb = 24'h0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (FC / 2) @(posedge clk);
    #2 begin mode_sel = 3'd3; solid_rgb = 24'h123456; end
    repeat (FC) @(posedge clk);
    #2 mode_sel = 3'd1;
    repeat (FC) @(posedge clk);
    #2 mode_sel = 3'd2;
    repeat (FC) @(posedge clk);
    #2 mode_sel = 3'd4;
    repeat (11 * FC) @(posedge clk);
    #2 mode_sel = 3'd6;
    repeat (FC) @(posedge clk);
    #2 mode_sel = 3'd4;
    repeat (FC) @(posedge clk);
    #2 mode_sel = 3'd0;
    repeat (40) @(posedge clk);
    #2 reset_n = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("fs_after_release", {31'b0, frame_start}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("fcnt_after_release", {16'b0, frame_cnt}, 32'd1);
    repeat (FC / 2) @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
